memory_responder: RTL

- Memory-side responder for the CPU's rd/wr memory interface.
- Holds a DEPTH x DATA_WIDTH word store and accepts one read or write request at a time.
- Inserts a programmable number of wait states before each access, then answers with a single-cycle ready pulse; reads return data on data_out.
- Flags malformed requests and out-of-range addresses on err.

---
 rtl/memory_responder_if.sv | 26 ++
 rtl/memory_responder.sv | 125 ++++++++++++
 2 files changed

// File: rtl/memory_responder_if.sv
// Request/response bus between the CPU memory port and the memory responder.
interface memory_responder_if #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  rd;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  ready;
  logic                  busy;
  logic                  err;

  // Requester side (CPU).
  modport master (
    output rd, wr, addr, data_in,
    input  data_out, ready, busy, err
  );

  // Responder side (memory).
  modport slave (
    input  rd, wr, addr, data_in,
    output data_out, ready, busy, err
  );
endinterface

// File: rtl/memory_responder.sv
// Memory-side responder: word store with programmable wait states, one
// request at a time, single-cycle ready/err completion pulses.
module memory_responder #(
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clock,
  input  logic               reset,
  memory_responder_if.slave  bus
);
  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Range check is done one bit wider than both operands so DEPTH never truncates.
  localparam int unsigned CMP_W = (ADDR_WIDTH > 32) ? ADDR_WIDTH + 1 : 33;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  typedef struct packed {
    logic                  is_wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  req_t                  req_q, req_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  mem_we;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;

  assign in_range = (CMP_W'(req_q.addr) < CMP_W'(DEPTH));
  assign idx      = req_q.addr[IDX_W-1:0];

  // Next-state, request latch, completion outputs and write strobe.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    data_out_d = data_out_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    busy_d     = busy_q;
    mem_we     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.rd ^ bus.wr) begin
          req_d.is_wr = bus.wr;
          req_d.addr  = bus.addr;
          req_d.data  = bus.data_in;
          cnt_d       = CNT_LOAD;
          state_d     = ST_WAIT;
          busy_d      = 1'b1;
        end else if (bus.rd && bus.wr) begin
          // Ambiguous request: reject immediately, nothing else changes.
          ready_d = 1'b1;
          err_d   = 1'b1;
        end
      end

      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (in_range) begin
            if (req_q.is_wr) mem_we = 1'b1;
            else             data_out_d = mem_q[idx];
          end else begin
            err_d = 1'b1;
            if (!req_q.is_wr) data_out_d = '0;
          end
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      data_out_q <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Word store; cleared on reset so an aborted write never lands.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[idx] <= req_q.data;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;
endmodule
